// File: rtl/dmi_crc_tx_seq_pkg.sv
// -----------------------------------------------------------------------------
// dmi_crc_pkg
// Shared definitions for the CRC-32 transmit sequencer: FSM state encoding,
// CRC constants, default minimum payload length and a bit-reverse helper.
// Optional build macro used by the sequencer: DMI_CRC_PAD_EN.
// -----------------------------------------------------------------------------
package dmi_crc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_PAD  = 3'd2,
    ST_FCS0 = 3'd3,
    ST_FCS1 = 3'd4
  } state_e;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam int          MIN_WORDS_DEF = 30;

  // Mirror a 32-bit word end for end (bit 0 <-> bit 31).
  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmi_crc_tx_seq_if.sv
// -----------------------------------------------------------------------------
// dmi_crc_tx_seq_if
// Upstream and downstream word streams of the CRC transmit sequencer.
//   i_data/i_valid/i_last/o_ready  : upstream words (i_data[15:8] first on wire)
//   o_data/o_valid/o_last/i_out_ready : downstream words with FCS appended
// slave  : seen from the sequencer
// master : seen from the environment driving the sequencer
// -----------------------------------------------------------------------------
interface dmi_crc_tx_seq_if;
  logic [15:0] i_data;
  logic        i_valid;
  logic        i_last;
  logic        o_ready;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_last;
  logic        i_out_ready;

  modport slave (
    input  i_data, i_valid, i_last, i_out_ready,
    output o_ready, o_data, o_valid, o_last
  );

  modport master (
    output i_data, i_valid, i_last, i_out_ready,
    input  o_ready, o_data, o_valid, o_last
  );
endinterface

// File: rtl/dmi_crc32_d16.sv
// -----------------------------------------------------------------------------
// dmi_crc32_d16
// Combinational next-state of the IEEE 802.3 CRC-32 for one 16-bit word.
// The high byte goes first; each byte is consumed LSB first (bit reflected)
// through an MSB-first shift register with polynomial CRC_POLY.
//   crc_i  : current CRC register
//   data_i : 16-bit data word
//   crc_o  : CRC register after absorbing data_i
// -----------------------------------------------------------------------------
module dmi_crc32_d16
  import dmi_crc_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [15:0] data_i,
  output logic [31:0] crc_o
);

  // Bit-serial CRC unrolled over both bytes of the word.
  always_comb begin
    logic [31:0] c_v;
    logic [7:0]  byte_v;
    logic        fb_v;
    c_v    = crc_i;
    byte_v = 8'h00;
    fb_v   = 1'b0;
    for (int b = 0; b < 2; b++) begin
      byte_v = (b == 0) ? data_i[15:8] : data_i[7:0];
      for (int k = 0; k < 8; k++) begin
        fb_v = c_v[31] ^ byte_v[k];
        c_v  = {c_v[30:0], 1'b0} ^ (fb_v ? CRC_POLY : 32'h0000_0000);
      end
    end
    crc_o = c_v;
  end

endmodule

// File: rtl/dmi_crc_tx_seq.sv
// -----------------------------------------------------------------------------
// dmi_crc_tx_seq
// Forwards 16-bit frame words through one output register stage and appends
// the IEEE 802.3 FCS (two words, second one flagged last). Optionally pads
// short frames with zero words up to MIN_WORDS payload words.
// Build macro: DMI_CRC_PAD_EN -- when defined, PAD state and MIN_WORDS are live.
// Ports:
//   i_clk       : clock, rising edge
//   i_rst       : asynchronous active-high reset
//   i_abort     : synchronous abort, drops the current frame
//   o_frame_cnt : completed-frame counter (wraps)
//   bus         : upstream/downstream word streams (slave modport)
// -----------------------------------------------------------------------------
module dmi_crc_tx_seq
  import dmi_crc_pkg::*;
#(
  parameter int MIN_WORDS = MIN_WORDS_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_abort,
  output logic [15:0]        o_frame_cnt,
  dmi_crc_tx_seq_if.slave    bus
);

`ifdef DMI_CRC_PAD_EN
  localparam logic PAD_EN = 1'b1;
`else
  localparam logic PAD_EN = 1'b0;
`endif
  localparam logic [15:0] MIN_W16 = 16'(MIN_WORDS);

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic        out_free_s;
  logic        in_ready_s;
  logic        accept_s;
  logic        go_pad_s;
  logic [15:0] cnt_inc_s;
  logic [15:0] crc_din_s;
  logic [31:0] crc_next_s;
  logic [31:0] fcs_r_s;

  assign out_free_s = !valid_q || bus.i_out_ready;
  assign in_ready_s = ((state_q == ST_IDLE) || (state_q == ST_DATA)) && out_free_s;
  // abort wins over any upstream transfer in the same cycle
  assign accept_s   = bus.i_valid && in_ready_s && !i_abort;
  // saturating so a huge frame never looks short again
  assign cnt_inc_s  = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
  assign go_pad_s   = PAD_EN && (cnt_inc_s < MIN_W16);
  assign crc_din_s  = (state_q == ST_PAD) ? 16'h0000 : bus.i_data;
  assign fcs_r_s    = bitrev32(~crc_q);

  dmi_crc32_d16 u_crc (
    .crc_i  (crc_q),
    .data_i (crc_din_s),
    .crc_o  (crc_next_s)
  );

  // Next-state and output-register logic of the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    frame_cnt_d = frame_cnt_q;

    // held word leaves when downstream takes it; branches below may reload
    if (out_free_s) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      valid_d = valid_q;
      last_d  = last_q;
    end

    // only the FCS1 word carries last, so its transfer closes a frame
    if (valid_q && last_q && bus.i_out_ready) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          data_d  = bus.i_data;
          valid_d = 1'b1;
          crc_d   = crc_next_s;
          cnt_d   = 16'd1;
          state_d = bus.i_last ? (go_pad_s ? ST_PAD : ST_FCS0) : ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          data_d  = bus.i_data;
          valid_d = 1'b1;
          crc_d   = crc_next_s;
          cnt_d   = cnt_inc_s;
          state_d = bus.i_last ? (go_pad_s ? ST_PAD : ST_FCS0) : ST_DATA;
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef DMI_CRC_PAD_EN
      ST_PAD: begin
        if (out_free_s) begin
          data_d  = 16'h0000;
          valid_d = 1'b1;
          crc_d   = crc_next_s;
          cnt_d   = cnt_inc_s;
          state_d = (cnt_inc_s >= MIN_W16) ? ST_FCS0 : ST_PAD;
        end else begin
          state_d = ST_PAD;
        end
      end
`endif
      ST_FCS0: begin
        if (out_free_s) begin
          data_d  = {fcs_r_s[7:0], fcs_r_s[15:8]};
          valid_d = 1'b1;
          state_d = ST_FCS1;
        end else begin
          state_d = ST_FCS0;
        end
      end
      ST_FCS1: begin
        if (out_free_s) begin
          data_d  = {fcs_r_s[23:16], fcs_r_s[31:24]};
          valid_d = 1'b1;
          last_d  = 1'b1;
          cnt_d   = 16'd0;
          crc_d   = CRC_INIT;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FCS1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
        crc_d   = CRC_INIT;
      end
    endcase

    if (i_abort) begin
      state_d     = ST_IDLE;
      valid_d     = 1'b0;
      last_d      = 1'b0;
      data_d      = 16'h0000;
      cnt_d       = 16'd0;
      crc_d       = CRC_INIT;
      frame_cnt_d = frame_cnt_q;
    end else begin
      state_d = state_d;
    end
  end

  // State, CRC and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC_INIT;
      cnt_q       <= 16'd0;
      data_q      <= 16'h0000;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.o_ready  = in_ready_s;
  assign bus.o_data   = data_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_last   = last_q;
  assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: doc/dmi_crc_tx_seq.md
DMI_CRC_TX_SEQ -- requirements
Module: dmi_crc_tx_seq

Interface
REQ-001 SHALL have parameter MIN_WORDS, default 30, minimum frame payload in 16-bit words before FCS (used only with padding).
REQ-002 SHALL have port i_clk, input, 1, sole clock; all logic on rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have ports i_data (input, 16), i_valid (input, 1), i_last (input, 1), o_ready (output, 1): upstream frame words; i_data[15:8] is the first byte on the wire; all frames have an even byte count.
REQ-005 SHALL have ports o_data (output, 16), o_valid (output, 1), o_last (output, 1), i_out_ready (input, 1): downstream frame words with FCS appended.
REQ-006 SHALL have port i_abort, input, 1, synchronous frame abort.
REQ-007 SHALL have port o_frame_cnt, output, 16, count of completed frames.

Function
REQ-008 SHALL implement FSM IDLE, DATA, PAD, FCS0, FCS1.
REQ-009 CRC SHALL be IEEE 802.3 CRC-32: poly 0x04C11DB7, each byte bit-reflected, high byte first, register init 0xFFFFFFFF.
REQ-010 CRC register SHALL load 0xFFFFFFFF on entry to DATA from IDLE and SHALL update only on an accepted input word or an emitted pad word.
REQ-011 A transfer SHALL occur when valid and ready are both high on the same edge, on either side.
REQ-012 o_ready SHALL be high only in IDLE or DATA, and only when (!o_valid || i_out_ready).
REQ-013 Output SHALL be one register stage: an accepted input word appears on o_data/o_valid the next cycle (latency 1).
REQ-014 o_data/o_valid/o_last SHALL stay stable while o_valid && !i_out_ready.
REQ-015 IDLE SHALL go to DATA on the first accepted word; the word is forwarded and CRC-ed.
REQ-016 An accepted word with i_last SHALL go to PAD if the word count is below MIN_WORDS and padding is enabled, otherwise to FCS0.
REQ-017 PAD SHALL emit 0x0000 words, CRC-ed, until the word count reaches MIN_WORDS, then go to FCS0.
REQ-018 With R = bit-reverse32(~CRC), FCS0 SHALL emit {R[7:0],R[15:8]} and FCS1 SHALL emit {R[23:16],R[31:24]} with o_last=1, then return to IDLE.
REQ-019 A frame with one word and i_last SHALL be legal.
REQ-020 The frame word counter SHALL saturate at 0xFFFF and never wrap into a false short frame.
REQ-021 o_frame_cnt SHALL increment when the FCS1 word transfers and SHALL wrap 0xFFFF to 0x0000.
REQ-022 i_abort SHALL force IDLE and clear o_valid next edge in any state, without incrementing o_frame_cnt; it takes priority over all transfers in that cycle.
REQ-023 i_valid in FCS0/FCS1/PAD SHALL be ignored (o_ready low); the next frame starts only from IDLE.

Reset
REQ-024 i_rst SHALL immediately force state IDLE, o_valid=0, o_last=0, o_data=0x0000, o_frame_cnt=0, CRC=0xFFFFFFFF.
REQ-025 o_ready SHALL be 1 in reset-released IDLE; reset mid-frame SHALL discard the frame with no FCS emitted.

Configuration
REQ-026 Macro DMI_CRC_PAD_EN SHALL compile in padding: when defined, PAD state and MIN_WORDS are active.
REQ-027 When DMI_CRC_PAD_EN is undefined, PAD logic SHALL be absent, i_last SHALL always go to FCS0, and MIN_WORDS SHALL have no effect.

Structure
REQ-028 Package dmi_crc_pkg SHALL hold the FSM state enum, CRC_INIT = 32'hFFFFFFFF, CRC_POLY, and the MIN_WORDS default.
REQ-029 Sub-module dmi_crc32_d16 SHALL be the combinational next-CRC function (16-bit data in, 32-bit CRC in/out); dmi_crc_tx_seq instantiates it once.

Verification
REQ-030 Padding off: words 0x0000,0x0000 (last), i_out_ready=1 -> output 0x0000,0x0000,0x1CDF,0x4421 (last); o_frame_cnt=1.
REQ-031 Padding on, MIN_WORDS=30: 2-word zero frame -> 30 words of 0x0000 then 2 FCS words equal to CRC-32 over 60 zero bytes; total 32 output words, last flag only on word 32.
REQ-032 Backpressure: i_out_ready toggled 1/0 each cycle on a 4-word frame -> output words unchanged while stalled; no drop or duplicate; FCS identical to the no-stall run.
REQ-033 i_abort asserted in DATA after 3 words, then a new 2-word zero frame -> no FCS for the aborted frame; new frame FCS = 0x1CDF,0x4421; o_frame_cnt=1.
REQ-034 i_rst pulsed during FCS0 -> o_valid=0 immediately, state IDLE, o_frame_cnt=0; the next frame is correct.
REQ-035 Preload o_frame_cnt to 0xFFFF by 65535 frames, run one more frame -> o_frame_cnt=0x0000.
